// File: rtl/write_commit_seq_if.sv
// Memory -> writeback bundle handshake.
// One bundle carries up to LANES retiring instructions; lane 0 is the oldest.
//   in_valid / in_ready : bundle handshake, transfer when both are high
//   in_lane_valid       : per-lane valid, expected contiguous from lane 0
//   in_pc               : lane PCs, LANES x 32
//   in_wen / in_dst     : lane GPR write enable / destination, LANES x 5
//   in_value            : lane write data, LANES x DATA_W
//   in_exc / in_eret    : lane raised an exception / lane is ERET
//   in_mtc0             : lane is MTC0, never writes a GPR
// master = Memory stage side, slave = write_commit_seq.
interface write_commit_seq_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_lane_valid;
    logic [LANES*32-1:0]     in_pc;
    logic [LANES-1:0]        in_wen;
    logic [LANES*5-1:0]      in_dst;
    logic [LANES*DATA_W-1:0] in_value;
    logic [LANES-1:0]        in_exc;
    logic [LANES-1:0]        in_eret;
    logic [LANES-1:0]        in_mtc0;

    modport master (
        output in_valid, in_lane_valid, in_pc, in_wen, in_dst,
               in_value, in_exc, in_eret, in_mtc0,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_lane_valid, in_pc, in_wen, in_dst,
               in_value, in_exc, in_eret, in_mtc0,
        output in_ready
    );
endinterface

// File: rtl/write_commit_seq.sv
// N-lane writeback/commit stage.
// Commits a retiring bundle's GPR writes in program order, truncated at the first
// excepting/ERET lane, then serialises the committed lanes onto the debug trace
// port one per cycle while back-pressuring Memory. Also holds the CP0 Count/Compare
// timer and the registered Cause.IP[7:2] sample.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   bus (slave)         : bundle handshake from Memory
//   rf_we/rf_dst/rf_value : GPR write port, one lane slice per lane
//   flush_o             : one-cycle pulse, bundle was cut by an exception/ERET
//   w_pc/w_reg/w_value/w_enable : debug trace port
//   ext_int             : external interrupt lines
//   count_we/compare_we/cp0_wdata : CP0 Count/Compare writes
//   count_o, ip_o       : CP0 Count and Cause.IP
//
// state | meaning
// IDLE  | no committed lanes left to trace, ready for a bundle
// TRACE | presenting committed lane idx_q on the trace port
module write_commit_seq #(
    parameter int LANES     = 2,
    parameter int DATA_W    = 32,
    parameter int COUNT_DIV = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    write_commit_seq_if.slave       bus,
    output logic [LANES-1:0]        rf_we,
    output logic [LANES*5-1:0]      rf_dst,
    output logic [LANES*DATA_W-1:0] rf_value,
    output logic                    flush_o,
    output logic [31:0]             w_pc,
    output logic [4:0]              w_reg,
    output logic [DATA_W-1:0]       w_value,
    output logic [3:0]              w_enable,
    input  logic [5:0]              ext_int,
    input  logic                    count_we,
    input  logic                    compare_we,
    input  logic [31:0]             cp0_wdata,
    output logic [31:0]             count_o,
    output logic [7:0]              ip_o
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int KW    = $clog2(LANES + 1);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    typedef enum logic {IDLE, TRACE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        k_last_q;
    logic [LANES*32-1:0]     pc_q;
    logic [LANES*5-1:0]      dst_q;
    logic [LANES*DATA_W-1:0] val_q;
    logic [LANES-1:0]        we_q;
    logic [LANES-1:0]        rf_we_q;
    logic                    flush_q;

    logic                    prefix;
    logic                    cut_seen;
    logic                    flush_d;
    logic [LANES-1:0]        we_d;
    logic [KW-1:0]           k_d;
    logic [IDX_W-1:0]        k_last_d;
    logic                    last_trace;
    logic                    accept;

    // Capture decode. A lane commits while the valid run from lane 0 is unbroken
    // and no older lane has cut the bundle; committed lanes are therefore always
    // lanes 0..K-1, which lets the trace walk lanes by plain index.
    always_comb begin
        prefix   = 1'b1;
        cut_seen = 1'b0;
        flush_d  = 1'b0;
        we_d     = '0;
        k_d      = '0;
        for (int i = 0; i < LANES; i++) begin
            prefix = prefix & bus.in_lane_valid[i];
            if (!cut_seen && (bus.in_exc[i] || bus.in_eret[i])) begin
                cut_seen = 1'b1;
                flush_d  = prefix;
            end
            if (!cut_seen && prefix) begin
                we_d[i] = bus.in_wen[i] && !bus.in_mtc0[i] && (bus.in_dst[i*5 +: 5] != 5'd0);
                k_d     = k_d + 1'b1;
            end
        end
        k_last_d = IDX_W'(k_d - 1'b1);
    end

    assign last_trace   = (state_q == TRACE) && (idx_q == k_last_q);
    assign bus.in_ready = !reset && ((state_q == IDLE) || last_trace);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept && (k_d != '0)) begin
                    state_d = TRACE;
                    idx_d   = '0;
                end
            end
            TRACE: begin
                if (last_trace) begin
                    // A bundle taken on the last trace cycle restarts without a bubble.
                    if (accept && (k_d != '0)) begin
                        state_d = TRACE;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= '0;
            dst_q    <= '0;
            val_q    <= '0;
            we_q     <= '0;
            k_last_q <= '0;
            rf_we_q  <= '0;
            flush_q  <= 1'b0;
        end else begin
            rf_we_q <= accept ? we_d : '0;
            flush_q <= accept && flush_d;
            if (accept) begin
                pc_q     <= bus.in_pc;
                dst_q    <= bus.in_dst;
                val_q    <= bus.in_value;
                we_q     <= we_d;
                k_last_q <= k_last_d;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_dst   = dst_q;
    assign rf_value = val_q;
    assign flush_o  = flush_q;

    always_comb begin
        w_pc     = '0;
        w_reg    = '0;
        w_value  = '0;
        w_enable = '0;
        if (state_q == TRACE) begin
            for (int i = 0; i < LANES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    w_pc     = pc_q[i*32 +: 32];
                    w_reg    = dst_q[i*5 +: 5];
                    w_value  = val_q[i*DATA_W +: DATA_W];
                    w_enable = {4{we_q[i]}};
                end
            end
        end
    end

    logic [DIV_W-1:0] div_q;
    logic [31:0]      count_q;
    logic [31:0]      compare_q;
    logic [31:0]      count_inc;
    logic             ti_q;
    logic [7:0]       ip_q;
    logic             tick;

    assign tick      = (div_q == DIV_W'(COUNT_DIV - 1));
    assign count_inc = count_q + 32'd1;

    // A Count write overrides the same-cycle tick, so that tick can never raise TI;
    // a Compare write clears TI even if the tick would have set it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
            ip_q      <= '0;
        end else begin
            if (count_we) begin
                count_q <= cp0_wdata;
                div_q   <= '0;
            end else if (tick) begin
                count_q <= count_inc;
                div_q   <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (compare_we) begin
                compare_q <= cp0_wdata;
                ti_q      <= 1'b0;
            end else if (!count_we && tick && (count_inc == compare_q)) begin
                ti_q <= 1'b1;
            end
            ip_q <= {ext_int[5] | ti_q, ext_int[4:0], 2'b00};
        end
    end

    assign count_o = count_q;
    assign ip_o    = ip_q;
endmodule
